// File: rtl/m_lsu_bus_pkg.sv
// Shared definitions for the memory-stage load/store bus master:
// exception codes, access sizes, FSM states and timer window helpers.
package m_lsu_bus_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam logic [31:0] TC_WIN = 32'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  // True when a lies in [base, base+len); the subtraction is guarded by a >= base.
  function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                     input logic [31:0] len);
    return (a >= base) && ((a - base) < len);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Pure combinational byte-lane steering for stores and lane extraction plus
// sign/zero extension for loads. Shared with the instruction-side bus master.
module lsu_lane_align
  import m_lsu_bus_pkg::*;
#(
  parameter  int DW    = 32,
  localparam int LANES = DW / 8,
  localparam int LB    = $clog2(LANES)
) (
  input  logic [1:0]       i_size,
  input  logic [LB-1:0]    i_lane,
  input  logic             i_signed,
  input  logic [DW-1:0]    i_wdata,
  input  logic [DW-1:0]    i_rdata,
  output logic [LANES-1:0] o_byteen,
  output logic [DW-1:0]    o_wdata,
  output logic [DW-1:0]    o_rdata
);

  logic [LANES-1:0] w_ones;
  logic [LB-1:0]    w_rep_mask;
  logic [DW-1:0]    w_shifted;
  logic [DW-1:0]    w_keep;
  logic             w_sign;
  int               w_nbits;

  always_comb begin
    w_ones     = LANES'(8'h01);
    w_rep_mask = LB'(3'd0);
    w_nbits    = 8;
    case (i_size)
      SZ_BYTE: begin w_ones = LANES'(8'h01); w_rep_mask = LB'(3'd0); w_nbits = 8;  end
      SZ_HALF: begin w_ones = LANES'(8'h03); w_rep_mask = LB'(3'd1); w_nbits = 16; end
      SZ_WORD: begin w_ones = LANES'(8'h0f); w_rep_mask = LB'(3'd3); w_nbits = 32; end
      default: begin w_ones = LANES'(8'hff); w_rep_mask = LB'(3'd7); w_nbits = 64; end
    endcase
  end

  assign o_byteen = w_ones << i_lane;

  // Replicating the low 2^size bytes across the bus puts them on every
  // naturally aligned lane group, including the enabled one.
  always_comb begin
    o_wdata = '0;
    for (int j = 0; j < LANES; j++) begin
      o_wdata[j*8 +: 8] = i_wdata[{(LB'(j) & w_rep_mask), 3'b000} +: 8];
    end
  end

  assign w_shifted = i_rdata >> {i_lane, 3'b000};

  always_comb begin
    w_keep = '0;
    for (int b = 0; b < DW; b++) begin
      w_keep[b] = (b < w_nbits);
    end
  end

  // Top kept bit is the sign bit; isolating it avoids an out-of-range index.
  assign w_sign  = |(w_shifted & w_keep & ~(w_keep >> 1));
  assign o_rdata = (w_shifted & w_keep) | ((i_signed && w_sign) ? ~w_keep : '0);

endmodule

// File: rtl/m_lsu_bus.sv
// Memory-stage load/store unit: address checks, lane steering and a
// request/acknowledge bus master that stalls the pipeline until acknowledged.
module m_lsu_bus
  import m_lsu_bus_pkg::*;
#(
  parameter  int          DW         = 32,
  parameter  logic [31:0] DM_HI      = 32'h0000_2fff,
  parameter  logic [31:0] TC0_BASE   = 32'h0000_7f00,
  parameter  logic [31:0] TC1_BASE   = 32'h0000_7f10,
  parameter  int          TC_CNT_OFF = 8,
  localparam int          LANES      = DW / 8,
  localparam int          LB         = $clog2(LANES)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_op_valid,
  input  logic             i_op_store,
  input  logic [1:0]       i_op_size,
  input  logic             i_op_signed,
  input  logic [31:0]      i_addr,
  input  logic [DW-1:0]    i_wdata,
  input  logic             i_int_req,
  input  logic [4:0]       i_in_exc,
  output logic             o_stall,
  output logic [DW-1:0]    o_rdata,
  output logic [4:0]       o_exc_code,
  output logic             o_bus_req,
  output logic             o_bus_we,
  output logic [31:0]      o_bus_addr,
  output logic [DW-1:0]    o_bus_wdata,
  output logic [LANES-1:0] o_bus_byteen,
  input  logic             i_bus_ack,
  input  logic [DW-1:0]    i_bus_rdata,
  output lsu_state_t       o_dbg_state
);

  // Bus handshake: o_bus_req rises the cycle after issue and the bus_* outputs
  // hold steady until the first cycle i_bus_ack is sampled high; that cycle
  // completes the transfer and o_bus_req drops on the following edge.

  lsu_state_t       r_state;
  lsu_state_t       w_state_nxt;
  logic             r_bus_req;
  logic             r_bus_we;
  logic [31:0]      r_bus_addr;
  logic [DW-1:0]    r_bus_wdata;
  logic [LANES-1:0] r_bus_byteen;
  logic [DW-1:0]    r_rdata;
  logic [1:0]       r_size;
  logic [LB-1:0]    r_lane;
  logic             r_signed;

  logic             w_size_bad, w_misalign, w_in_ram, w_in_tc, w_cnt_hit, w_bad;
  logic [31:0]      w_align_mask;
  logic [4:0]       w_loc_exc, w_exc;
  logic             w_issue, w_stall, w_launch, w_capture;
  logic [1:0]       w_al_size;
  logic [LB-1:0]    w_al_lane;
  logic             w_al_signed;
  logic [LANES-1:0] w_byteen;
  logic [DW-1:0]    w_wdata_st;
  logic [DW-1:0]    w_rdata_ext;

  assign w_size_bad   = int'(i_op_size) > LB;
  assign w_align_mask = (32'd1 << i_op_size) - 32'd1;
  assign w_misalign   = |(i_addr & w_align_mask);
  assign w_in_ram     = i_addr <= DM_HI;
  assign w_in_tc      = in_window(i_addr, TC0_BASE, TC_WIN) |
                        in_window(i_addr, TC1_BASE, TC_WIN);
  assign w_cnt_hit    = in_window(i_addr, TC0_BASE + 32'(TC_CNT_OFF), 32'd4) |
                        in_window(i_addr, TC1_BASE + 32'(TC_CNT_OFF), 32'd4);
  assign w_bad        = w_size_bad | w_misalign | !(w_in_ram | w_in_tc) |
                        (w_in_tc & (i_op_size < SZ_WORD)) | (i_op_store & w_cnt_hit);

  assign w_loc_exc  = (i_op_valid && w_bad) ? (i_op_store ? EXC_ADES : EXC_ADEL) : EXC_NONE;
  assign w_exc      = (w_loc_exc != EXC_NONE) ? w_loc_exc : i_in_exc;
  assign o_exc_code = w_exc;
  assign w_issue    = i_op_valid && (w_exc == EXC_NONE) && !i_int_req && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_issue)   w_state_nxt = ST_BUSY;
      ST_BUSY: if (i_bus_ack) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_stall   = 1'b0;
    w_launch  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall  = w_issue;
        w_launch = w_issue;
      end
      ST_BUSY: begin
        w_stall   = 1'b1;
        w_capture = i_bus_ack;
      end
      default: ;
    endcase
  end

  // The aligner sees the live op while idle and the launched op while busy.
  assign w_al_size   = (r_state == ST_BUSY) ? r_size   : i_op_size;
  assign w_al_lane   = (r_state == ST_BUSY) ? r_lane   : i_addr[LB-1:0];
  assign w_al_signed = (r_state == ST_BUSY) ? r_signed : i_op_signed;

  lsu_lane_align #(.DW(DW)) u_align (
    .i_size   (w_al_size),
    .i_lane   (w_al_lane),
    .i_signed (w_al_signed),
    .i_wdata  (i_wdata),
    .i_rdata  (i_bus_rdata),
    .o_byteen (w_byteen),
    .o_wdata  (w_wdata_st),
    .o_rdata  (w_rdata_ext)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_byteen <= '0;
      r_rdata      <= '0;
      r_size       <= SZ_BYTE;
      r_lane       <= '0;
      r_signed     <= 1'b0;
    end else if (w_launch) begin
      r_bus_req    <= 1'b1;
      r_bus_we     <= i_op_store;
      r_bus_addr   <= i_addr;
      r_bus_wdata  <= w_wdata_st;
      r_bus_byteen <= w_byteen;
      r_size       <= i_op_size;
      r_lane       <= i_addr[LB-1:0];
      r_signed     <= i_op_signed;
    end else if (w_capture) begin
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_byteen <= '0;
      // Stores return no meaningful data, so the last load result is kept.
      if (!r_bus_we) r_rdata <= w_rdata_ext;
    end
  end

  assign o_stall      = w_stall & !i_reset;
  assign o_rdata      = r_rdata;
  assign o_bus_req    = r_bus_req;
  assign o_bus_we     = r_bus_we;
  assign o_bus_addr   = r_bus_addr;
  assign o_bus_wdata  = r_bus_wdata;
  assign o_bus_byteen = r_bus_byteen;
  assign o_dbg_state  = r_state;

endmodule
